// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the register-file write port between WB and a FIFO of MD results, tracking pending writes.
module rf_wport_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_en,
   input  logic [3:0]  wb_wn,
   input  logic [31:0] wb_wd,
   input  logic        md_valid,
   input  logic [3:0]  md_wn,
   input  logic [31:0] md_wd,
   output logic        md_ready,
   input  logic [3:0]  rn1,
   input  logic [3:0]  rn2,
   input  logic [3:0]  rd_dst,
   output logic        hazard,
   output logic [15:0] pend_mask,
   output logic        md_starve,
   output logic        rf_en,
   output logic [3:0]  rf_wn,
   output logic [31:0] rf_wd
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   logic [3:0]    wn_q [DEPTH];
   logic [3:0]    wn_d [DEPTH];
   logic [31:0]   wd_q [DEPTH];
   logic [31:0]   wd_d [DEPTH];
   logic [AW-1:0] rp_q, rp_d, wp_q, wp_d, off;
   logic [AW:0]   cnt_q, cnt_d;
   logic [3:0]    sc_q, sc_d;
   logic          init_q, init_d;
   logic          wb_act, nonempty, pop, push;
   logic [15:0]   pm;

   // rst_n gates the grant so an in-flight write is killed asynchronously
   always_comb begin
      wb_act   = rst_n && wb_en && wb_wn != 4'd0;
      nonempty = cnt_q != '0;
      pop      = rst_n && !wb_act && nonempty;
      md_ready = init_q && cnt_q < FULL;
      push     = md_valid && md_ready && md_wn != 4'd0;
   end

   always_comb begin
      rf_en     = wb_act || pop;
      rf_wn     = wb_act ? wb_wn : pop ? wn_q[rp_q] : 4'd0;
      rf_wd     = wb_act ? wb_wd : pop ? wd_q[rp_q] : 32'd0;
      md_starve = sc_q == LIM;
   end

   always_comb begin
      pm  = '0;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rp_q;
         if ({1'b0, off} < cnt_q) pm[wn_q[i]] = 1'b1;
      end
      pend_mask = {pm[15:1], 1'b0};
      hazard    = pend_mask[rn1] | pend_mask[rn2] | pend_mask[rd_dst];
   end

   always_comb begin
      wn_d = wn_q;
      wd_d = wd_q;
      if (push) begin
         wn_d[wp_q] = md_wn;
         wd_d[wp_q] = md_wd;
      end
      wp_d   = wp_q + AW'(push);
      rp_d   = rp_q + AW'(pop);
      cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      sc_d   = (!nonempty || pop) ? 4'd0 : (sc_q >= LIM) ? LIM : sc_q + 4'd1;
      init_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            wn_q[i] <= '0;
            wd_q[i] <= '0;
         end
         rp_q   <= '0;
         wp_q   <= '0;
         cnt_q  <= '0;
         sc_q   <= '0;
         init_q <= 1'b0;
      end else begin
         wn_q   <= wn_d;
         wd_q   <= wd_d;
         rp_q   <= rp_d;
         wp_q   <= wp_d;
         cnt_q  <= cnt_d;
         sc_q   <= sc_d;
         init_q <= init_d;
      end
   end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed scenario tasks for rf_wport_arbiter (DEPTH=2, STARVE_LIM=4).
module tb_rf_wport_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_en, md_valid;
   logic [3:0]  wb_wn, md_wn, rn1, rn2, rd_dst;
   logic [31:0] wb_wd, md_wd;
   logic        md_ready, hazard, md_starve, rf_en;
   logic [15:0] pend_mask;
   logic [3:0]  rf_wn;
   logic [31:0] rf_wd;
   int          checks = 0;
   int          errors = 0;

   rf_wport_arbiter #(.DEPTH(2), .STARVE_LIM(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_en(wb_en), .wb_wn(wb_wn), .wb_wd(wb_wd),
      .md_valid(md_valid), .md_wn(md_wn), .md_wd(md_wd), .md_ready(md_ready),
      .rn1(rn1), .rn2(rn2), .rd_dst(rd_dst), .hazard(hazard), .pend_mask(pend_mask),
      .md_starve(md_starve), .rf_en(rf_en), .rf_wn(rf_wn), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      rst_n = 1'b0; wb_en = 1'b1; wb_wn = 4'd3; wb_wd = 32'h55; md_valid = 1'b0;
      md_wn = '0; md_wd = '0; rn1 = '0; rn2 = '0; rd_dst = '0;
      @(negedge clk); #1;
      checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL rst_rf_en got %b exp 0", rf_en); end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rst_md_ready got %b exp 0", md_ready); end
      checks++; if (rf_wn !== 4'd0 || rf_wd !== 32'd0) begin errors++; $display("FAIL rst_rf_data got %h/%h exp 0/0", rf_wn, rf_wd); end
      checks++; if (pend_mask !== 16'd0 || hazard !== 1'b0 || md_starve !== 1'b0) begin errors++; $display("FAIL rst_status got %h %b %b exp 0 0 0", pend_mask, hazard, md_starve); end
      wb_en = 1'b0;
      @(negedge clk); rst_n = 1'b1; #1;
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rel_md_ready_early got %b exp 0", md_ready); end
      @(negedge clk); #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rel_md_ready got %b exp 1", md_ready); end
   endtask

   task automatic test_wb;
      @(negedge clk); wb_en = 1'b1; wb_wn = 4'd3; wb_wd = 32'hDEADBEEF; #1;
      checks++; if (rf_en !== 1'b1 || rf_wn !== 4'd3 || rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_pass got %b %h %h exp 1 3 deadbeef", rf_en, rf_wn, rf_wd); end
      @(negedge clk); wb_wn = 4'd0; #1;
      checks++; if (rf_en !== 1'b0 || rf_wn !== 4'd0 || rf_wd !== 32'd0) begin errors++; $display("FAIL wb_r0 got %b %h %h exp 0 0 0", rf_en, rf_wn, rf_wd); end
      wb_en = 1'b0;
   endtask

   task automatic test_md;
      @(negedge clk); md_valid = 1'b1; md_wn = 4'd5; md_wd = 32'h1234; #1;
      checks++; if (md_ready !== 1'b1 || rf_en !== 1'b0) begin errors++; $display("FAIL md_accept got rdy %b en %b exp 1 0", md_ready, rf_en); end
      @(negedge clk); md_valid = 1'b0; #1;
      checks++; if (rf_en !== 1'b1 || rf_wn !== 4'd5 || rf_wd !== 32'h1234) begin errors++; $display("FAIL md_write got %b %h %h exp 1 5 1234", rf_en, rf_wn, rf_wd); end
      checks++; if (pend_mask !== 16'h0020) begin errors++; $display("FAIL md_pend got %h exp 0020", pend_mask); end
      @(negedge clk); #1;
      checks++; if (pend_mask !== 16'h0000 || rf_en !== 1'b0) begin errors++; $display("FAIL md_drain got %h %b exp 0000 0", pend_mask, rf_en); end
      md_valid = 1'b1; md_wn = 4'd0; md_wd = 32'h77; #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL md_r0_ready got %b exp 1", md_ready); end
      @(negedge clk); md_valid = 1'b0; #1;
      checks++; if (rf_en !== 1'b0 || pend_mask !== 16'd0 || md_ready !== 1'b1) begin errors++; $display("FAIL md_r0_discard got %b %h %b exp 0 0000 1", rf_en, pend_mask, md_ready); end
   endtask

   task automatic test_full;
      @(negedge clk); wb_en = 1'b1; wb_wn = 4'd1; wb_wd = 32'h11;
      md_valid = 1'b1; md_wn = 4'd6; md_wd = 32'h66; #1;
      checks++; if (md_ready !== 1'b1 || rf_wn !== 4'd1) begin errors++; $display("FAIL full_p1 got %b %h exp 1 1", md_ready, rf_wn); end
      @(negedge clk); md_wn = 4'd7; md_wd = 32'h77; #1;
      checks++; if (md_ready !== 1'b1 || pend_mask !== 16'h0040 || rf_wn !== 4'd1) begin errors++; $display("FAIL full_p2 got %b %h %h exp 1 0040 1", md_ready, pend_mask, rf_wn); end
      @(negedge clk); md_wn = 4'd8; md_wd = 32'h88; #1;
      checks++; if (md_ready !== 1'b0 || pend_mask !== 16'h00C0) begin errors++; $display("FAIL full_stall got %b %h exp 0 00c0", md_ready, pend_mask); end
      @(negedge clk); wb_en = 1'b0; #1;
      checks++; if (md_ready !== 1'b0 || rf_en !== 1'b1 || rf_wn !== 4'd6 || rf_wd !== 32'h66) begin errors++; $display("FAIL order_6 got %b %b %h %h exp 0 1 6 66", md_ready, rf_en, rf_wn, rf_wd); end
      @(negedge clk); #1;
      checks++; if (md_ready !== 1'b1 || rf_wn !== 4'd7 || rf_wd !== 32'h77) begin errors++; $display("FAIL order_7 got %b %h %h exp 1 7 77", md_ready, rf_wn, rf_wd); end
      @(negedge clk); md_valid = 1'b0; #1;
      checks++; if (rf_en !== 1'b1 || rf_wn !== 4'd8 || rf_wd !== 32'h88 || pend_mask !== 16'h0100) begin errors++; $display("FAIL order_8 got %b %h %h %h exp 1 8 88 0100", rf_en, rf_wn, rf_wd, pend_mask); end
      @(negedge clk); #1;
      checks++; if (rf_en !== 1'b0 || pend_mask !== 16'd0) begin errors++; $display("FAIL order_empty got %b %h exp 0 0000", rf_en, pend_mask); end
   endtask

   task automatic test_starve;
      @(negedge clk); wb_en = 1'b1; wb_wn = 4'd2; wb_wd = 32'h22;
      md_valid = 1'b1; md_wn = 4'd10; md_wd = 32'hAA;
      @(negedge clk); md_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (j > 0) @(negedge clk);
         #1;
         checks++; if (md_starve !== (j >= 4) || rf_wn !== 4'd2) begin errors++; $display("FAIL starve_%0d got %b %h exp %b 2", j, md_starve, rf_wn, j >= 4); end
      end
      @(negedge clk); wb_en = 1'b0; #1;
      checks++; if (rf_en !== 1'b1 || rf_wn !== 4'd10 || rf_wd !== 32'hAA || md_starve !== 1'b1) begin errors++; $display("FAIL starve_drain got %b %h %h %b exp 1 a aa 1", rf_en, rf_wn, rf_wd, md_starve); end
      @(negedge clk); #1;
      checks++; if (md_starve !== 1'b0 || rf_en !== 1'b0) begin errors++; $display("FAIL starve_clear got %b %b exp 0 0", md_starve, rf_en); end
   endtask

   task automatic test_hazard;
      @(negedge clk); wb_en = 1'b1; wb_wn = 4'd4; wb_wd = 32'h44;
      md_valid = 1'b1; md_wn = 4'd9; md_wd = 32'h1; rn1 = 4'd9; rn2 = '0; rd_dst = '0;
      @(negedge clk); md_wd = 32'h2; #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_one got %b exp 1", hazard); end
      @(negedge clk); md_valid = 1'b0; rn1 = '0; #1;
      checks++; if (hazard !== 1'b0 || pend_mask !== 16'h0200) begin errors++; $display("FAIL haz_r0 got %b %h exp 0 0200", hazard, pend_mask); end
      rd_dst = 4'd9; #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_rd got %b exp 1", hazard); end
      rd_dst = '0; rn2 = 4'd9; #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_rn2 got %b exp 1", hazard); end
      @(negedge clk); wb_en = 1'b0; rn2 = '0; rn1 = 4'd9; #1;
      checks++; if (hazard !== 1'b1 || rf_wn !== 4'd9 || rf_wd !== 32'h1) begin errors++; $display("FAIL haz_pop1 got %b %h %h exp 1 9 1", hazard, rf_wn, rf_wd); end
      @(negedge clk); #1;
      checks++; if (hazard !== 1'b1 || rf_wd !== 32'h2) begin errors++; $display("FAIL haz_pop2 got %b %h exp 1 2", hazard, rf_wd); end
      @(negedge clk); #1;
      checks++; if (hazard !== 1'b0 || pend_mask !== 16'd0) begin errors++; $display("FAIL haz_clear got %b %h exp 0 0000", hazard, pend_mask); end
      rn1 = '0;
   endtask

   task automatic test_reset_mid;
      @(negedge clk); wb_en = 1'b1; wb_wn = 4'd3; wb_wd = 32'h33;
      md_valid = 1'b1; md_wn = 4'd12; md_wd = 32'hC;
      @(negedge clk); md_wn = 4'd13; md_wd = 32'hD;
      @(negedge clk); md_valid = 1'b0; wb_en = 1'b0; rn1 = 4'd12; #1;
      checks++; if (rf_en !== 1'b1 || rf_wn !== 4'd12 || pend_mask !== 16'h3000) begin errors++; $display("FAIL mid_pre got %b %h %h exp 1 c 3000", rf_en, rf_wn, pend_mask); end
      rst_n = 1'b0; #1;
      checks++; if (rf_en !== 1'b0 || rf_wn !== 4'd0 || rf_wd !== 32'd0) begin errors++; $display("FAIL mid_rf got %b %h %h exp 0 0 0", rf_en, rf_wn, rf_wd); end
      checks++; if (md_ready !== 1'b0 || pend_mask !== 16'd0 || hazard !== 1'b0 || md_starve !== 1'b0) begin errors++; $display("FAIL mid_status got %b %h %b %b exp 0 0 0 0", md_ready, pend_mask, hazard, md_starve); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (md_ready !== 1'b1 || pend_mask !== 16'd0 || rf_en !== 1'b0) begin errors++; $display("FAIL mid_after got %b %h %b exp 1 0000 0", md_ready, pend_mask, rf_en); end
      @(negedge clk); #1;
      checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL mid_stale got %b exp 0", rf_en); end
      rn1 = '0;
   endtask

   initial begin
      test_reset;
      test_wb;
      test_md;
      test_full;
      test_starve;
      test_hazard;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Write-port arbiter and pending-write scoreboard for the 16×32 register file in the 5-stage pipeline. Shares the register file's single write port between the pipeline writeback stage (WB) and the multi-cycle multiply/divide unit (MD). MD results are buffered in a small FIFO. The block also tracks which registers have buffered writes outstanding, so decode can stall on hazards.

## Interface
- `DEPTH`, 2: MD result FIFO entries; power of 2, ≥2.
- `STARVE_LIM`, 4: cycles the FIFO head may lose arbitration before a bubble is requested; 1..15.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  single clock; state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_en`  in  1  WB write request.
- `wb_wn`  in  4  WB destination register.
- `wb_wd`  in  32  WB write data.
- `md_valid`  in  1  MD result valid.
- `md_wn`  in  4  MD destination register.
- `md_wd`  in  32  MD result data.
- `md_ready`  out  1  FIFO can accept an MD result.
- `rn1`, `rn2`  in  4 each  decode-stage source registers.
- `rd_dst`  in  4  decode-stage destination register.
- `hazard`  out  1  decode must stall.
- `pend_mask`  out  16  bit i set = buffered write to register i outstanding.
- `md_starve`  out  1  request a WB bubble next cycle.
- `rf_en`  out  1  drives the register file `EnRW`.
- `rf_wn`  out  4  drives the register file `WN`.
- `rf_wd`  out  32  drives the register file `WD`.

## Operation
- **Combinational write port.** The register file captures on the negedge of the same cycle in which the grant is made.
- **Effective WB request:** `wb_act = wb_en && wb_wn != 0`.
- **Grant, WB priority:**
  - If `wb_act`: `rf_en=1`, `rf_wn=wb_wn`, `rf_wd=wb_wd`. The FIFO head is not granted.
  - Else if the FIFO is non-empty: `rf_en=1`, `rf_wn/rf_wd` = head. The head is popped at the posedge.
  - Else: `rf_en=0`, `rf_wn=0`, `rf_wd=0`.
- **FIFO push.**
  - Push happens when `md_valid && md_ready` at posedge.
  - `md_ready = (count < DEPTH)`, from registered count only. It is not raised by a same-cycle pop.
  - Entries with `md_wn == 0` are discarded on acceptance: handshake completes, nothing is stored.
- **Simultaneous push and pop** (count < DEPTH) leaves count unchanged. Order is strictly FIFO.
- **`pend_mask`** is the OR over valid FIFO entries of `1 << wn`, computed combinationally from storage. A bit stays set while any entry targets that register. Bit 0 is always 0.
- **`hazard`** = `pend_mask[rn1] | pend_mask[rn2] | pend_mask[rd_dst]`; register 0 never hazards. Upstream guarantees WB never targets a register in `pend_mask`, so WAW ordering holds.
- **Starvation counter `sc`** (4-bit):
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise increments, saturating at `STARVE_LIM`.
  - `md_starve = (sc == STARVE_LIM)`.
  - Upstream must drop `wb_en` the following cycle. If `wb_en` remains asserted, WB still wins.

## Timing
- **Reset (async, `rst_n=0`):**
  - FIFO emptied, `sc=0`.
  - `md_ready=0`, `rf_en=0`, `rf_wn=0`, `rf_wd=0`, `pend_mask=0`, `hazard=0`, `md_starve=0`.
  - `rf_en` is gated low while `rst_n=0`.
- **After reset:** `md_ready=1` from the first posedge after `rst_n` rises.
- **Reset mid-operation:** all buffered entries are lost. No partial write: `rf_en` drops asynchronously.
- **WB latency:** 0 cycles. The write lands at the negedge of the request cycle.
- **MD latency:** accepted at posedge N; earliest write at the negedge of cycle N+1, if WB is idle. `pend_mask` bit sets in cycle N+1 and clears after the popping posedge.
- **Full:** `md_ready=0` for exactly the cycles with count==DEPTH. `md_valid` with `md_ready=0` leaves the MD unit holding its data.
- **Empty:** no grant from the FIFO; `sc` held at 0.
- **Pointer wrap:** read/write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. Count is `log2(DEPTH)+1` bits.

## Test plan
- **Reset / idle.**
  - Stimulus: assert `rst_n=0` mid-run with 2 entries buffered.
  - Required: all outputs 0 immediately; after release, `md_ready=1`, `pend_mask=0`, and no write of stale entries.
- **WB passthrough.**
  - Stimulus: `wb_en=1`, `wb_wn=3`, `wb_wd=32'hDEADBEEF`.
  - Required: `rf_en=1`, `rf_wn=3`, `rf_wd=32'hDEADBEEF` the same cycle.
  - Stimulus: `wb_wn=0`.
  - Required: `rf_en=0`.
- **MD buffered write.**
  - Stimulus: with WB idle, push `md_wn=5`, `md_wd=32'h1234`.
  - Required: next cycle `rf_wn=5`, `rf_wd=32'h1234`, `pend_mask=16'h0020`; following cycle `pend_mask=0`.
  - Stimulus: push `md_wn=0`.
  - Required: accepted, no write.
- **Full / ordering.**
  - Stimulus: hold `wb_en=1` to reg 1; push MD to regs 6, 7, 8.
  - Required: third push stalls (`md_ready=0`); `pend_mask=16'h00C0`.
  - Stimulus: release WB.
  - Required: writes to 6, then 7, then 8 in consecutive cycles.
- **Starvation.**
  - Stimulus: one entry buffered; `wb_en=1` continuously.
  - Required: `md_starve=1` after `STARVE_LIM`=4 lost cycles.
  - Stimulus: drop `wb_en` one cycle.
  - Required: head written, `sc` and `md_starve` clear.
- **Hazard.**
  - Stimulus: entries for regs 9 and 9 buffered.
  - Required: `hazard=1` for `rn1=9`; still set after the first pop; clear after the second.
  - Stimulus: `rn1=rn2=rd_dst=0`.
  - Required: `hazard=0`.
